byte_frame_serializer: RTL
==========================

Name: byte_frame_serializer

Overview:
- Downstream stage of the rotating byte frame buffer: consumes its 8-bit output stream one byte at a time.
- Shifts each byte out MSB-first on a 3-wire serial bus (data/clock/latch) to an external shift-register or LED driver chain.
- Frames are WORD_COUNT bytes long, aligned by a frame_start tag on byte 0; a latch pulse closes each frame.
- Double-buffered (1-entry hold register plus shift register), so the buffer can run continuously without gaps.

Parameters:
- WORD_COUNT, 32, bytes per frame; byte index counter is clog2(WORD_COUNT) bits.
- LATCH_CYCLES, 2, clk cycles ser_latch is held high at end of frame (1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  byte from frame buffer.
- in_valid  input  1  in_data valid this cycle.
- in_frame_start  input  1  qualifies in_data as byte 0 of a frame.
- in_ready  output  1  hold register empty; byte accepted when in_valid && in_ready.
- ser_data  output  1  serial data, MSB first.
- ser_clk  output  1  serial clock; the sink samples on rising edge.
- ser_latch  output  1  frame latch strobe.
- frame_done  output  1  one-cycle pulse when a full frame is latched.
- resync  output  1  one-cycle pulse when a frame is cut short by an early frame_start.

Behaviour:
- Reset (async, rst_n=0): state=WAIT_SYNC, hold empty, shift empty, byte index 0, bit count 0, phase 0.
  - Outputs during and after reset until the first load: in_ready=1, ser_data=0, ser_clk=0, ser_latch=0, frame_done=0, resync=0.
- Hold register:
  - in_ready = !hold_valid, registered.
  - On accept, captures in_data and in_frame_start.
  - Emptied on the edge its contents move to the shift register.
- WAIT_SYNC:
  - Accepted bytes without the frame_start tag are dropped (hold cleared the next cycle).
  - A tagged byte moves to the shift register; state goes to SHIFT with byte index 0.
- SHIFT: each bit takes 2 cycles.
  - Phase 0: ser_clk=0, ser_data=current bit.
  - Phase 1: ser_clk=1, ser_data unchanged.
  - 8 bits = 16 cycles per byte.
- Load timing:
  - A byte held at edge N into an empty shifter is loaded at edge N+1.
  - Its MSB appears on ser_data after edge N+1; the first ser_clk rise follows edge N+2.
- Back-to-back bytes: if hold is valid at the edge ending bit 0's phase 1, the next byte loads on that same edge with no idle cycle.
- Underflow: if hold is empty at byte end (and the frame is not complete), the shifter goes idle.
  - ser_clk=0, ser_data holds its last value, byte index is retained.
  - Shifting resumes on the next load.
- Frame end: when the byte with index WORD_COUNT-1 finishes, state goes to LATCH.
  - ser_latch=1 for exactly LATCH_CYCLES cycles, ser_clk=0.
  - frame_done pulses in the last latch cycle.
  - Then index=0 and state=SHIFT (or idle if hold is empty).
  - Hold may accept during LATCH; no load until LATCH exits.
- Expected tag: a tagged byte arriving at index 0 is normal.
- Untagged byte at index 0 after a latch: accepted as byte 0 (free-running alignment).
- Early frame_start (tagged byte loaded while index≠0):
  - Partial frame is abandoned with no latch.
  - resync pulses one cycle on the load edge; index reset to 0.
- Reset mid-frame or mid-latch: immediate return to the reset state; ser_latch drops asynchronously.
- Simultaneous accept and load on one edge is legal: the hold is refilled while its old contents load.

Test Plan:
- Reset, then feed 32 bytes 0x00..0x1F every 16 cycles, byte 0 tagged.
  - Expect: 256 ser_clk rises; bit stream = the bytes MSB-first.
  - Expect: ser_latch high 2 cycles after the last fall; frame_done a single pulse; zero idle cycles between bytes.
- Before the first tag, send 0xAA and 0x55 untagged.
  - Expect: no ser_clk activity, in_ready stays cycling.
  - Then send tagged 0xC3: serial 11000011 appears.
- Send tagged 0x80 with in_valid held high continuously.
  - Expect: in_ready low while hold is full; exactly one accept per 16 cycles in steady state.
- After 5 bytes, send a tagged byte 0xF0.
  - Expect: resync pulse, no ser_latch; frame then completes after 32 further bytes with frame_done.
- Gap of 40 cycles after byte 10.
  - Expect: ser_clk=0 during the gap; serial resumes with the correct byte; latch only after byte 31.
- Assert rst_n low during the latch.
  - Expect: ser_latch=0 immediately, in_ready=1, bytes dropped until the next tagged byte.

Source files
------------

// File: rtl/byte_frame_serializer_if.sv
// Byte-stream input and 3-wire serial output bundle for byte_frame_serializer.
// master = byte source / bus observer side, slave = serializer side.
interface byte_frame_serializer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_frame_start;
  logic       in_ready;
  logic       ser_data;
  logic       ser_clk;
  logic       ser_latch;
  logic       frame_done;
  logic       resync;

  modport master (
    output in_data, in_valid, in_frame_start,
    input  in_ready, ser_data, ser_clk, ser_latch, frame_done, resync
  );

  modport slave (
    input  in_data, in_valid, in_frame_start,
    output in_ready, ser_data, ser_clk, ser_latch, frame_done, resync
  );
endinterface

// File: rtl/byte_frame_serializer.sv
// Frame-aligned byte serializer: 1-entry hold register feeding an MSB-first
// shifter that drives a data/clock/latch chain, latching after WORD_COUNT bytes.
module byte_frame_serializer #(
  parameter int WORD_COUNT   = 32,
  parameter int LATCH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  byte_frame_serializer_if.slave bus
);
  localparam int IW = $clog2(WORD_COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_COUNT - 1);

  typedef enum logic [1:0] {WAIT_SYNC, SHIFT, IDLE, LATCH} state_t;

  state_t          state;
  logic            hold_valid, hold_tag;
  logic [7:0]      hold_data;
  logic [6:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic            phase;
  logic [IW-1:0]   idx;
  logic [3:0]      latch_cnt;
  logic            in_ready, ser_data, ser_clk, ser_latch, frame_done, resync;

  logic            byte_end, shifter_free, do_load, drop, accept;
  logic [IW-1:0]   load_idx;

  assign bus.in_ready   = in_ready;
  assign bus.ser_data   = ser_data;
  assign bus.ser_clk    = ser_clk;
  assign bus.ser_latch  = ser_latch;
  assign bus.frame_done = frame_done;
  assign bus.resync     = resync;

  // load_idx is the frame index the byte in the hold register would take if loaded now
  always_comb begin
    byte_end     = (state == SHIFT) && phase && (bit_cnt == 3'd0);
    accept       = bus.in_valid && in_ready;
    shifter_free = 1'b0;
    load_idx     = idx;
    case (state)
      WAIT_SYNC: begin shifter_free = 1'b1; load_idx = '0; end
      IDLE:      shifter_free = 1'b1;
      SHIFT:     begin shifter_free = byte_end && (idx != LAST_IDX); load_idx = idx + IW'(1); end
      LATCH:     begin shifter_free = (latch_cnt == 4'd0); load_idx = '0; end
      default:   ;
    endcase
    do_load = hold_valid && shifter_free && ((state != WAIT_SYNC) || hold_tag);
    drop    = hold_valid && (state == WAIT_SYNC) && !hold_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SYNC;
      hold_valid <= 1'b0;
      hold_tag   <= 1'b0;
      hold_data  <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      idx        <= '0;
      latch_cnt  <= '0;
      in_ready   <= 1'b1;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      resync     <= 1'b0;

      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.in_data;
        hold_tag   <= bus.in_frame_start;
      end else if (do_load || drop) begin
        hold_valid <= 1'b0;
      end
      in_ready <= !(accept || (hold_valid && !(do_load || drop)));

      if (do_load) begin
        state     <= SHIFT;
        shift_reg <= hold_data[6:0];
        ser_data  <= hold_data[7];
        bit_cnt   <= 3'd7;
        phase     <= 1'b0;
        ser_clk   <= 1'b0;
        ser_latch <= 1'b0;
        // a tag always restarts the frame; it is only unexpected off index 0
        idx       <= hold_tag ? '0 : load_idx;
        resync    <= hold_tag && (load_idx != '0);
      end else begin
        case (state)
          SHIFT: begin
            if (!phase) begin
              phase   <= 1'b1;
              ser_clk <= 1'b1;
            end else begin
              phase   <= 1'b0;
              ser_clk <= 1'b0;
              if (bit_cnt != 3'd0) begin
                bit_cnt   <= bit_cnt - 3'd1;
                ser_data  <= shift_reg[6];
                shift_reg <= {shift_reg[5:0], 1'b0};
              end else if (idx == LAST_IDX) begin
                state      <= LATCH;
                ser_latch  <= 1'b1;
                latch_cnt  <= 4'(LATCH_CYCLES - 1);
                frame_done <= (LATCH_CYCLES == 1);
              end else begin
                state <= IDLE;
                idx   <= idx + IW'(1);
              end
            end
          end
          LATCH: begin
            if (latch_cnt == 4'd0) begin
              ser_latch <= 1'b0;
              idx       <= '0;
              state     <= IDLE;
            end else begin
              latch_cnt  <= latch_cnt - 4'd1;
              frame_done <= (latch_cnt == 4'd1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
